// File: rtl/hdmi_period_sched_if.sv
// hdmi_period_sched_if: packet handshake and per-pixel period/timing bundle of the HDMI scheduler
// master: scheduler side (takes en/pkt_req, drives everything else)
// slave : packet source and TMDS encoder side
interface hdmi_period_sched_if;
    logic       en;
    logic       pkt_req;
    logic       pkt_ack;
    logic       pkt_rd;
    logic [4:0] pkt_idx;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       vde;
    logic [2:0] mode;
    logic [3:0] ctl;
    logic       frame_start;
    modport master (
        input  en, pkt_req,
        output pkt_ack, pkt_rd, pkt_idx, hcount, vcount, hsync, vsync, vde, mode, ctl, frame_start
    );
    modport slave (
        output en, pkt_req,
        input  pkt_ack, pkt_rd, pkt_idx, hcount, vcount, hsync, vsync, vde, mode, ctl, frame_start
    );
endinterface

// File: rtl/hdmi_period_sched.sv
// hdmi_period_sched: raster timing and per-pixel HDMI period sequencing with one data island per line
// pixclk/rst : pixel clock, synchronous active-high reset
// bus        : en, pkt_req in; pkt_ack, pkt_rd, pkt_idx, hcount, vcount, hsync, vsync, vde, mode, ctl, frame_start out
module hdmi_period_sched #(
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter logic SYNC_POL     = 1'b1,
    parameter int   ISLAND_START = 660
) (
    input logic pixclk,
    input logic rst,
    hdmi_period_sched_if.master bus
);
    typedef enum logic [2:0] {
        CTRL, VID_PRE, VID_GB, VID_DATA, DI_PRE, DI_LGB, DI_DATA, DI_TGB
    } mode_e;
    localparam logic [9:0] HA      = 10'(H_ACTIVE);
    localparam logic [9:0] VA      = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] PRE_BEG = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 10);
    localparam logic [9:0] GB_BEG  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 2);
    localparam logic [9:0] IS      = 10'(ISLAND_START);
    localparam logic [9:0] IS_END  = 10'(ISLAND_START + 44);
    logic       isl;
    logic       isl_n;
    logic [9:0] nh;
    logic [9:0] nv;
    logic [9:0] nl;
    logic [9:0] d;
    mode_e      mode_n;
    // Everything is computed for the pixel about to be registered, so all outputs stay aligned with hcount/vcount.
    always_comb begin
        nh = (bus.hcount == H_LAST) ? 10'd0 : bus.hcount + 10'd1;
        nv = (bus.hcount != H_LAST) ? bus.vcount : (bus.vcount == V_LAST) ? 10'd0 : bus.vcount + 10'd1;
        nl = (nv == V_LAST) ? 10'd0 : nv + 10'd1;
        d = nh - IS;
        // The island commits only on the edge entering ISLAND_START and then runs to completion unless reset.
        isl_n = (nh == IS) ? bus.pkt_req : isl && nh > IS && nh < IS_END;
        mode_n = (nh < HA && nv < VA) ? VID_DATA :
                 isl_n ? (d < 10'd8 ? DI_PRE : d < 10'd10 ? DI_LGB : d < 10'd42 ? DI_DATA : DI_TGB) :
                 (nl < VA && nh >= PRE_BEG) ? (nh < GB_BEG ? VID_PRE : VID_GB) : CTRL;
    end
    always_ff @(posedge pixclk) begin
        if (rst || !bus.en) begin
            isl             <= 1'b0;
            bus.hcount      <= HA;
            bus.vcount      <= V_LAST;
            bus.mode        <= CTRL;
            bus.ctl         <= 4'd0;
            bus.vde         <= 1'b0;
            bus.pkt_ack     <= 1'b0;
            bus.pkt_rd      <= 1'b0;
            bus.pkt_idx     <= 5'd0;
            bus.frame_start <= 1'b0;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
        end else begin
            isl             <= isl_n;
            bus.hcount      <= nh;
            bus.vcount      <= nv;
            bus.mode        <= mode_n;
            bus.ctl         <= mode_n == VID_PRE ? 4'b0001 : mode_n == DI_PRE ? 4'b0101 : 4'b0000;
            bus.vde         <= mode_n == VID_DATA;
            bus.pkt_ack     <= nh == IS && bus.pkt_req;
            bus.pkt_rd      <= mode_n == DI_DATA;
            bus.pkt_idx     <= mode_n == DI_DATA ? 5'(d - 10'd10) : 5'd0;
            bus.frame_start <= nh == 10'd0 && nv == 10'd0;
            bus.hsync       <= (nh >= HS_BEG && nh < HS_END) ? SYNC_POL : ~SYNC_POL;
            bus.vsync       <= (nv >= VS_BEG && nv < VS_END) ? SYNC_POL : ~SYNC_POL;
        end
    end
endmodule

// File: tb/tb_hdmi_period_sched.sv
// tb_hdmi_period_sched: randomized self-checking bench for hdmi_period_sched on a reduced raster
module tb_hdmi_period_sched;
    localparam int   HA = 64, HFP = 8, HSW = 16, HBP = 72, HT = HA + HFP + HSW + HBP;
    localparam int   VA = 20, VFP = 3, VSW = 2, VBP = 5, VT = VA + VFP + VSW + VBP;
    localparam int   IS = 70;
    localparam logic POL = 1'b0;
    logic pixclk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int mh, mv, mk;
    bit mack;
    bit src;
    hdmi_period_sched_if bus();
    hdmi_period_sched #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(POL), .ISLAND_START(IS)
    ) dut (
        .pixclk(pixclk),
        .rst(rst),
        .bus(bus)
    );
    always #5 pixclk = ~pixclk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at h=%0d v=%0d t=%0t", tag, got, exp, mh, mv, $time);
        end
    endtask
    // Reference: position advances one pixel per clock; an island is a 44-cycle window timed from its grant.
    task automatic model_step(input logic r, input logic e, input logic q);
        if (r || !e) begin
            mh = HA;
            mv = VT - 1;
            mk = -1;
            mack = 0;
        end else begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end else mh++;
            if (mk >= 0) mk = (mk == 43) ? -1 : mk + 1;
            mack = (mh == IS) && q;
            if (mack) mk = 0;
        end
    endtask
    task automatic compare();
        int em;
        bit vid;
        bit nxt;
        vid = mh < HA && mv < VA;
        nxt = ((mv + 1) % VT) < VA;
        em = vid ? 3 : mk >= 0 ? (mk < 8 ? 4 : mk < 10 ? 5 : mk < 42 ? 6 : 7) :
             (nxt && mh >= HT - 10) ? (mh < HT - 2 ? 1 : 2) : 0;
        chk("hcount", bus.hcount, mh);
        chk("vcount", bus.vcount, mv);
        chk("mode", bus.mode, em);
        chk("ctl", bus.ctl, em == 1 ? 1 : em == 4 ? 5 : 0);
        chk("vde", bus.vde, int'(em == 3));
        chk("hsync", bus.hsync, (mh >= HA + HFP && mh < HA + HFP + HSW) ? POL : !POL);
        chk("vsync", bus.vsync, (mv >= VA + VFP && mv < VA + VFP + VSW) ? POL : !POL);
        chk("pkt_ack", bus.pkt_ack, mack);
        chk("pkt_rd", bus.pkt_rd, int'(em == 6));
        chk("pkt_idx", bus.pkt_idx, em == 6 ? mk - 10 : 0);
        chk("frame_start", bus.frame_start, int'(mh == 0 && mv == 0));
    endtask
    task automatic cycle(input logic r, input logic e, input logic q);
        rst = r;
        bus.en = e;
        bus.pkt_req = q;
        model_step(r, e, q);
        @(negedge pixclk);
        compare();
    endtask
    // Packet source: holds its request until the grant, then may reassert at once.
    task automatic src_next();
        if (src && mack) src = $urandom_range(0, 1) == 1;
        else if (!src) src = $urandom_range(0, 39) == 0;
    endtask
    task automatic first_frame(input string tag);
        int n = 0;
        do begin
            cycle(0, 1, 0);
            n++;
        end while (!bus.frame_start && n < 2 * HT);
        chk(tag, n, HT - HA);
    endtask
    initial begin
        int nv, nh, ns, n, acks;
        mh = HA; mv = VT - 1; mk = -1; mack = 0; src = 0;
        bus.en = 1'b1;
        bus.pkt_req = 1'b0;
        repeat (5) cycle(1, 1, 0);
        first_frame("fs_latency_rst");
        nv = 0; nh = 0; ns = 0;
        for (int i = 0; i < HT * VT; i++) begin
            nv += int'(bus.vde);
            nh += int'(bus.hsync == POL);
            ns += int'(bus.vsync == POL);
            cycle(0, 1, 0);
        end
        chk("vde_per_frame", nv, HA * VA);
        chk("hsync_per_frame", nh, HSW * VT);
        chk("vsync_per_frame", ns, VSW * HT);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            src_next();
            cycle(0, 1, src);
        end
        acks = 0;
        for (int i = 0; i < HT * VT; i++) begin
            acks += int'(bus.pkt_ack);
            cycle(0, 1, 1);
        end
        chk("acks_held_req", acks, VT);
        n = 0;
        while (mh != IS && n < 2 * HT) begin
            cycle(0, 1, 0);
            n++;
        end
        chk("reach_is", mh, IS);
        acks = 0;
        for (int i = 0; i < HT; i++) begin
            cycle(0, 1, 1);
            acks += int'(bus.pkt_ack);
        end
        chk("late_req_next_line", acks, 1);
        n = 0;
        while (!(mh == IS + 20 && mk >= 0) && n < 2 * HT) begin
            cycle(0, 1, 1);
            n++;
        end
        chk("reach_mid_island", mh, IS + 20);
        cycle(1, 1, 1);
        chk("abort_rd", bus.pkt_rd, 0);
        chk("abort_hcount", bus.hcount, HA);
        for (int i = 0; i < HT; i++) cycle(0, 1, 1);
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1);
            acks += int'(bus.pkt_ack);
        end
        chk("en_low_no_ack", acks, 0);
        first_frame("fs_latency_en");
        for (int i = 0; i < 2 * HT * VT; i++) begin
            src_next();
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 299) != 0, src);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hdmi_period_sched.md
# hdmi_period_sched

Sequencer for the HDMI TMDS transmit path. It generates raster timing and tells the three TMDS encoders which HDMI period is on the wire each pixel clock: control, video preamble, video guard band, active video, or data island. Data islands are granted to a single packet source via a request/acknowledge handshake. It sits between the pixel/packet sources and the per-channel TMDS encoders.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (H_TOTAL = sum = 800)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_POL, 1, asserted level of hsync/vsync
- ISLAND_START, 660, hcount of first data-island preamble cycle; must satisfy ISLAND_START >= H_ACTIVE+2 and ISLAND_START+44 <= H_TOTAL-22
- pixclk  in  1  pixel clock (already decided)
- rst  in  1  synchronous, active-high reset (already decided)
- en  in  1  run enable; low behaves as reset except that pkt_req is ignored
- pkt_req  in  1  packet source has a 32-cycle packet ready (level)
- pkt_ack  out  1  one-cycle grant pulse
- pkt_rd  out  1  high during the 32 island data cycles
- pkt_idx  out  5  packet cycle index while pkt_rd is high; 0 otherwise
- hcount  out  10  horizontal position
- vcount  out  10  vertical position
- hsync, vsync  out  1  sync outputs, polarity SYNC_POL
- vde  out  1  active video (mode == VID_DATA)
- mode  out  3  period: 0 CTRL, 1 VID_PRE, 2 VID_GB, 3 VID_DATA, 4 DI_PRE, 5 DI_LGB, 6 DI_DATA, 7 DI_TGB
- ctl  out  4  CTL3..CTL0 for the red/green encoders
- frame_start  out  1  high when hcount==0 and vcount==0

## Operation
- All outputs are registered and aligned: every output describes the same pixel as hcount/vcount.
- hcount counts 0..H_TOTAL-1 and wraps. vcount increments on the hcount wrap and counts 0..V_TOTAL-1, then wraps.
- hsync is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Both are gated on every line regardless of mode.
- VID_DATA: hcount < H_ACTIVE and vcount < V_ACTIVE.
- Video preamble and guard band are emitted only when the next line is active, i.e. (vcount+1) mod V_TOTAL < V_ACTIVE:
  - VID_PRE at hcount H_TOTAL-10..H_TOTAL-3, with ctl=4'b0001.
  - VID_GB at hcount H_TOTAL-2..H_TOTAL-1.
- Data island handshake:
  - pkt_req is sampled on the edge where the output hcount goes from ISLAND_START-1 to ISLAND_START, on any line.
  - If pkt_req is 1, the island commits and pkt_ack is 1 while hcount==ISLAND_START.
  - Island layout is 44 cycles: DI_PRE for 8 cycles (ctl=4'b0101), DI_LGB for 2, DI_DATA for 32 (pkt_rd=1, pkt_idx 0..31), DI_TGB for 2.
  - If pkt_req is 0, the island slot stays CTRL. There is at most one island per line.
- The source holds pkt_req until it sees pkt_ack. After the ack it may reassert immediately; the next grant is then on the following line.
- ctl is 0 in every mode other than VID_PRE and DI_PRE.
- Island and video periods never overlap; the parameter constraint above guarantees this.

## Timing
- Reset and en=0 values:
  - hcount=H_ACTIVE, vcount=V_TOTAL-1.
  - mode=CTRL, ctl=0, vde=0, pkt_ack=0, pkt_rd=0, pkt_idx=0, frame_start=0.
  - hsync, vsync deasserted (~SYNC_POL).
- First active pixel follows a complete preamble: the first frame_start occurs H_TOTAL-H_ACTIVE cycles after release.
- Reset or en falling mid-island aborts the island; outputs take reset values on the next cycle. A pkt_ack already given is not repeated.
- pkt_req rising in the cycle where hcount==ISLAND_START is too late; it is granted on the next line.
- Latency: pkt_ack to first pkt_rd is 10 cycles. pkt_idx=k is at hcount ISLAND_START+10+k.
- vcount wrap and hcount wrap are simultaneous at the frame boundary. frame_start, VID_DATA, and first-line state must be correct on that cycle.

## Test plan
- Reset release, defaults, pkt_req=0:
  - mode CTRL until hcount 790.
  - VID_PRE 790..797 with ctl=0001, VID_GB 798..799.
  - frame_start, vde=1 at (0,0).
- Full frame:
  - hsync asserted exactly for hcount 656..751 and vsync exactly for vcount 490..491.
  - vde count per frame = 307200.
  - No preamble at the end of lines 479..523.
  - Preamble present at the end of line 524.
- pkt_req held high from line 5:
  - pkt_ack at hcount 660 on every line.
  - DI_PRE 660..667 (ctl=0101), DI_LGB 668..669, DI_DATA 670..701 with pkt_idx 0..31, DI_TGB 702..703.
- pkt_req raised while hcount==660:
  - No island on that line.
  - Grant at hcount 660 of the next line.
- Reset asserted at hcount 680 mid-island:
  - Next cycle: reset values, pkt_rd=0.
  - After release, no pkt_ack until pkt_req is resampled at the next hcount 660.
- en low for 100 cycles then high:
  - Same sequence as the reset-release scenario.
  - pkt_req high during en=0 produces no ack.
